// File: rtl/window_pointer_unit.sv
// window_pointer_unit: owns the SPARC V8 current window pointer (CWP) and
// window invalid mask (WIM). It executes SAVE, RESTORE, RETT, trap entry and
// WRPSR/WRWIM, checks WIM on every SAVE/RESTORE/RETT window move, and raises
// window overflow/underflow requests to the trap controller through a
// req/ack handshake.
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   save/restore/rett   window-moving instructions (WIM checked)
//   trap_entry          external trap taken: CWP-1 without a WIM check
//   wr_psr_en/_cwp      WRPSR load of CWP
//   wr_wim_en/_data     WRWIM load of WIM (accepted in every state)
//   trap_ack            trap controller accepts the pending window trap
//   cwp, wim            registered window pointer and invalid mask
//   trap_req/trap_type  pending window trap; type 0 = overflow, 1 = underflow
//   busy                window trap pending; window commands are ignored
module window_pointer_unit #(
   parameter int unsigned NWINDOWS = 4,
   parameter int unsigned CWP_W    = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                save,
   input  logic                restore,
   input  logic                rett,
   input  logic                trap_entry,
   input  logic                wr_psr_en,
   input  logic [CWP_W-1:0]    wr_psr_cwp,
   input  logic                wr_wim_en,
   input  logic [NWINDOWS-1:0] wr_wim_data,
   input  logic                trap_ack,
   output logic [CWP_W-1:0]    cwp,
   output logic [NWINDOWS-1:0] wim,
   output logic                trap_req,
   output logic                trap_type,
   output logic                busy
);

   typedef enum logic {
      IDLE      = 1'b0,
      TRAP_PEND = 1'b1
   } state_t;

   state_t           state;
   logic [CWP_W-1:0] cwp_dec;
   logic [CWP_W-1:0] cwp_inc;

   // Neighbour windows; NWINDOWS == 2**CWP_W so the natural wrap is modulo NWINDOWS.
   assign cwp_dec = cwp - CWP_W'(1);
   assign cwp_inc = cwp + CWP_W'(1);

   // Window state machine; the WIM check always uses the registered wim.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cwp       <= '0;
         wim       <= '0;
         trap_req  <= 1'b0;
         trap_type <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (wr_wim_en) begin
            wim <= wr_wim_data;
         end

         case (state)
            IDLE: begin
               if (trap_entry) begin
                  cwp <= cwp_dec;
               end else if (wr_psr_en) begin
                  cwp <= wr_psr_cwp;
               end else if (rett || restore) begin
                  if (wim[cwp_inc]) begin
                     state     <= TRAP_PEND;
                     trap_req  <= 1'b1;
                     busy      <= 1'b1;
                     trap_type <= 1'b1;
                  end else begin
                     cwp <= cwp_inc;
                  end
               end else if (save) begin
                  if (wim[cwp_dec]) begin
                     state     <= TRAP_PEND;
                     trap_req  <= 1'b1;
                     busy      <= 1'b1;
                     trap_type <= 1'b0;
                  end else begin
                     cwp <= cwp_dec;
                  end
               end
            end

            TRAP_PEND: begin
               // Acceptance performs the trap-entry decrement.
               if (trap_ack) begin
                  state    <= IDLE;
                  cwp      <= cwp_dec;
                  trap_req <= 1'b0;
                  busy     <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_window_pointer_unit.sv
// Directed table-driven bench for window_pointer_unit, plus a hand sequence
// for asynchronous reset while a window trap is pending.
module tb_window_pointer_unit;

   typedef struct {
      logic       save;
      logic       restore;
      logic       rett;
      logic       trap_entry;
      logic       wr_psr_en;
      logic [1:0] wr_psr_cwp;
      logic       wr_wim_en;
      logic [3:0] wr_wim_data;
      logic       trap_ack;
      logic [1:0] e_cwp;
      logic [3:0] e_wim;
      logic       e_req;
      logic       e_type;
      logic       e_busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       save, restore, rett, trap_entry, wr_psr_en, wr_wim_en, trap_ack;
   logic [1:0] wr_psr_cwp;
   logic [3:0] wr_wim_data;
   logic [1:0] cwp;
   logic [3:0] wim;
   logic       trap_req, trap_type, busy;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   window_pointer_unit #(.NWINDOWS(4), .CWP_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .save(save), .restore(restore), .rett(rett), .trap_entry(trap_entry),
      .wr_psr_en(wr_psr_en), .wr_psr_cwp(wr_psr_cwp),
      .wr_wim_en(wr_wim_en), .wr_wim_data(wr_wim_data),
      .trap_ack(trap_ack),
      .cwp(cwp), .wim(wim), .trap_req(trap_req), .trap_type(trap_type), .busy(busy)
   );

   task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic [1:0] ec, input logic [3:0] ew,
                            input logic er, input logic et, input logic eb);
      check("cwp",       idx, 4'(cwp),       4'(ec));
      check("wim",       idx, wim,           ew);
      check("trap_req",  idx, 4'(trap_req),  4'(er));
      check("trap_type", idx, 4'(trap_type), 4'(et));
      check("busy",      idx, 4'(busy),      4'(eb));
   endtask

   task automatic idle_inputs();
      save = 0; restore = 0; rett = 0; trap_entry = 0; wr_psr_en = 0;
      wr_psr_cwp = 2'd0; wr_wim_en = 0; wr_wim_data = 4'd0; trap_ack = 0;
   endtask

   // s r rt te pe pc we wd ack | cwp wim req type busy (state after the edge)
   task automatic add(input logic s, input logic r, input logic rt, input logic te,
                      input logic pe, input logic [1:0] pc, input logic we,
                      input logic [3:0] wd, input logic ack,
                      input logic [1:0] ec, input logic [3:0] ew,
                      input logic er, input logic et, input logic eb);
      vec_t v;
      v.save = s; v.restore = r; v.rett = rt; v.trap_entry = te; v.wr_psr_en = pe;
      v.wr_psr_cwp = pc; v.wr_wim_en = we; v.wr_wim_data = wd; v.trap_ack = ack;
      v.e_cwp = ec; v.e_wim = ew; v.e_req = er; v.e_type = et; v.e_busy = eb;
      tbl.push_back(v);
   endtask

   initial begin
      // saves with wim=0: 0 -> 3 -> 2 -> 1
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd3,4'h0,0,0,0);
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd2,4'h0,0,0,0);
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd1,4'h0,0,0,0);
      // overflow: wim=0001, save from 1; commands ignored while pending; ack
      add(0,0,0,0,0,2'd0,1,4'h1,0, 2'd1,4'h1,0,0,0);
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd1,4'h1,1,0,1);
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd1,4'h1,1,0,1);
      add(0,1,0,0,0,2'd0,0,4'h0,0, 2'd1,4'h1,1,0,1);
      add(0,0,0,0,0,2'd0,0,4'h0,1, 2'd0,4'h1,0,0,0);
      // underflow on wrap 3 -> 0
      add(0,0,0,0,1,2'd3,0,4'h0,0, 2'd3,4'h1,0,0,0);
      add(0,1,0,0,0,2'd0,0,4'h0,0, 2'd3,4'h1,1,1,1);
      add(0,0,0,0,0,2'd0,0,4'h0,1, 2'd2,4'h1,0,1,0);
      add(0,0,0,0,0,2'd0,0,4'h0,1, 2'd2,4'h1,0,1,0);   // ack in IDLE: no effect
      add(0,0,0,0,1,2'd3,1,4'h0,0, 2'd3,4'h0,0,1,0);
      add(0,1,0,0,0,2'd0,0,4'h0,0, 2'd0,4'h0,0,1,0);   // wim=0: 3 -> 0
      // priority
      add(0,0,0,0,1,2'd2,0,4'h0,0, 2'd2,4'h0,0,1,0);
      add(1,0,0,1,1,2'd2,0,4'h0,0, 2'd1,4'h0,0,1,0);   // trap_entry wins
      add(0,1,0,0,1,2'd2,0,4'h0,0, 2'd2,4'h0,0,1,0);   // wr_psr beats restore
      // WIM write timing
      add(1,0,0,0,0,2'd0,1,4'h2,0, 2'd1,4'h2,0,1,0);   // old wim used
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd0,4'h2,0,1,0);
      add(0,1,0,0,0,2'd0,0,4'h0,0, 2'd0,4'h2,1,1,1);   // 0 -> 1 invalid
      add(1,0,0,0,0,2'd0,1,4'h0,0, 2'd0,4'h0,1,1,1);   // wim write in TRAP_PEND
      add(0,0,0,0,0,2'd0,0,4'h0,1, 2'd3,4'h0,0,1,0);   // ack: 0 -> 3
      // rett and trap_type changes
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd2,4'h0,0,1,0);
      add(0,0,0,0,0,2'd0,1,4'h8,0, 2'd2,4'h8,0,1,0);
      add(0,0,1,0,0,2'd0,0,4'h0,0, 2'd2,4'h8,1,1,1);   // rett 2 -> 3 invalid
      add(0,0,0,0,0,2'd0,0,4'h0,1, 2'd1,4'h8,0,1,0);
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd0,4'h8,0,1,0);
      add(1,0,0,0,0,2'd0,0,4'h0,0, 2'd0,4'h8,1,0,1);   // save 0 -> 3 invalid

      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_all(-1, 2'd0, 4'h0, 0, 0, 0);
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         save = tbl[i].save; restore = tbl[i].restore; rett = tbl[i].rett;
         trap_entry = tbl[i].trap_entry; wr_psr_en = tbl[i].wr_psr_en;
         wr_psr_cwp = tbl[i].wr_psr_cwp; wr_wim_en = tbl[i].wr_wim_en;
         wr_wim_data = tbl[i].wr_wim_data; trap_ack = tbl[i].trap_ack;
         @(posedge clk);
         #1;
         check_all(i, tbl[i].e_cwp, tbl[i].e_wim, tbl[i].e_req, tbl[i].e_type, tbl[i].e_busy);
      end

      // Async reset mid-cycle while in TRAP_PEND
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      #1;
      check_all(100, 2'd0, 4'h8, 1, 0, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_all(101, 2'd0, 4'h0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      save = 1'b1;
      @(posedge clk);
      #1;
      check_all(102, 2'd3, 4'h0, 0, 0, 0);
      @(negedge clk);
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
